// File: rtl/dadda_prod_accum.sv
`default_nettype none
// dadda_prod_accum: accumulates groups of multiplier products into a wide sum,
// presenting each finished group (sum, count, sticky carry) on a valid/ready port.
module dadda_prod_accum #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               res_ovf_q, res_ovf_d;

  logic [SUM_W-1:0]   add_w;
  logic [CNT_W-1:0]   cnt_inc_w;
  logic               ovf_upd_w;

  // Extra top bit of the adder captures the carry out of the accumulator.
  assign add_w     = {1'b0, acc_q} + SUM_W'(in_data);
  assign ovf_upd_w = ovf_q | add_w[ACC_W];
  assign cnt_inc_w = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    count_d   = count_q;
    res_ovf_d = res_ovf_q;
    in_ready  = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = !clear;
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          if (in_last) begin
            sum_d     = add_w[ACC_W-1:0];
            count_d   = cnt_inc_w;
            res_ovf_d = ovf_upd_w;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = ST_HOLD;
          end else begin
            acc_d = add_w[ACC_W-1:0];
            cnt_d = cnt_inc_w;
            ovf_d = ovf_upd_w;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  // The result is valid exactly while the block is holding it.
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = res_ovf_q;

endmodule
`default_nettype wire

// File: doc/dadda_prod_accum.md
Name: dadda_prod_accum

Overview:
- Downstream consumer of the DADDA_16x16 product output (32-bit `out`).
- Registers each 32-bit product and accumulates a group of products into a wide unsigned sum.
- A group is terminated by a `last` marker. The finished sum is presented on a valid/ready output port.
- Forms the accumulate half of a dot-product / MAC datapath built around the combinational multiplier.

Parameters:
- PROD_W, 32, product width; matches the 16x16 multiplier output.
- ACC_W, 40, accumulator width; must be greater than or equal to PROD_W.
- CNT_W, 8, width of the per-group product counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  PROD_W  unsigned product from the multiplier.
- in_last  in  1  beat is the final product of its group.
- clear  in  1  synchronous abort of the current group.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  group sum, modulo 2^ACC_W.
- out_count  out  CNT_W  number of products in the group, saturating.
- out_ovf  out  1  sticky flag: the group sum carried out of ACC_W.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=ACCUM; acc=0, cnt=0, ovf_r=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Sources must hold in_valid=0 while reset_n is low.
- State ACCUM:
  - in_ready = !clear.
  - Accept occurs when in_valid && in_ready.
  - On accept: acc <= acc + zero-extended in_data (wraps mod 2^ACC_W).
  - ovf_r <= ovf_r | carry-out of that add.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
- Accept with in_last=1:
  - At the same edge, out_sum/out_count/out_ovf are loaded with the updated acc/cnt/ovf_r, including the last beat.
  - out_valid <= 1 and state <= HOLD.
  - acc, cnt and ovf_r are cleared to 0.
  - Result latency: out_valid is high the cycle after the last beat is accepted.
- State HOLD:
  - in_ready=0.
  - out_* remain stable until out_valid && out_ready.
  - On that handshake: out_valid <= 0 and state <= ACCUM. No beat is accepted in the handshake cycle.
  - clear is ignored in HOLD.
- Throughput:
  - One beat per cycle within a group.
  - Minimum two-cycle gap between the last beat of one group and the first beat of the next (HOLD cycle plus handshake).
- clear=1 in ACCUM:
  - acc, cnt and ovf_r are zeroed at the edge.
  - A concurrent in_valid beat is not accepted, since in_ready=0.
  - out_* are unaffected.
- A single-beat group (first beat carries in_last) yields out_count=1.
- out_valid must not drop without a handshake, except by reset.
- Reset asserted mid-group or in HOLD discards all state immediately; out_valid falls asynchronously.
- All arithmetic is unsigned. There is no saturation of the sum; overflow is reported only via out_ovf.

Test Plan:
- Reset:
  - Stimulus: drive reset_n=0 mid-group after 2 accepted beats.
  - Response: out_valid=0, out_sum=0 immediately.
  - Stimulus: after release, send a one-beat group 0x00000005 with last.
  - Response: out_sum=0x0000000005, out_count=1, out_ovf=0.
- Basic group:
  - Stimulus: beats 0x00000006, 0xFFFE0001, 0x00010000 (last), back-to-back, out_ready=1.
  - Response: out_valid=1 one cycle after the third beat; out_sum=0x00FFFF0007, out_count=3, out_ovf=0.
- Backpressure:
  - Stimulus: complete a group while holding out_ready=0 for 5 cycles.
  - Response: out_valid and out_* stable and in_ready=0 throughout.
  - Stimulus: raise out_ready.
  - Response: handshake; out_valid=0 and in_ready=1 the next cycle.
- Overflow:
  - Stimulus: 257 beats of 0xFFFE0001, last on beat 257.
  - Response: out_sum=0x00FDFE0101, out_ovf=1, out_count=255 (saturated).
  - Stimulus: next group, single beat 0x1.
  - Response: out_ovf=0.
- Clear:
  - Stimulus: 2 beats of 0x10, then clear=1 with in_valid=1 and data 0x20.
  - Response: in_ready=0 and the beat is not consumed.
  - Stimulus: then beat 0x7 with last.
  - Response: out_sum=0x7, out_count=1.
- Clear in HOLD:
  - Stimulus: pulse clear while out_valid=1 and out_ready=0.
  - Response: out_sum unchanged; the result is delivered intact on a later out_ready.
